// File: rtl/hpu_axil_regs_if.sv
// AXI-Lite slave bus bundle for the HPU control-register block.
// Signal names follow the AXI-Lite port names used by the PS interconnect.
interface hpu_axil_regs_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/hpu_axil_regs.sv
// AXI-Lite register block for the HPU: CTRL (matw/run/last), W1C STATUS and
// NUM_REGS-2 byte-strobed parameter registers exported to the datapath.
module hpu_axil_regs #(
  parameter int          ADDR_W    = 12,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] PARAM_RST = 32'h0
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  hpu_axil_regs_if.slave               s_axi,
  input  logic                         matw_done,
  input  logic                         fin,
  output logic                         matw,
  output logic                         run,
  output logic                         last,
  output logic [(NUM_REGS-2)*32-1:0]   params
);
  localparam int         IDX_W       = ADDR_W - 2;
  localparam int         PARAM_W     = (NUM_REGS - 2) * 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_RA, S_R
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   awidx_q, awidx_d;
  logic [IDX_W-1:0]   aridx_q, aridx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;

  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               arready_q, arready_d;
  logic               bvalid_q, bvalid_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [2:0]         ctrl_q, ctrl_d;
  logic               done_q, done_d;
  logic               seen_q, seen_d;
  logic [PARAM_W-1:0] params_q, params_d;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx_raw;
  logic [31:0]        wr_data;
  logic [3:0]         wr_strb;
  logic [31:0]        wr_idx, rd_idx;
  logic               wr_ok, rd_ok;
  logic [31:0]        rd_data;
  logic               unused_addr_lsbs;

  function automatic logic idx_in_range(input logic [31:0] idx);
    return idx < 32'(NUM_REGS);
  endfunction

  assign unused_addr_lsbs = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Transaction sequencing; the write strobe fires on the edge that enters B
  always_comb begin
    state_d    = state_q;
    awidx_d    = awidx_q;
    aridx_d    = aridx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_en      = 1'b0;
    wr_idx_raw = awidx_q;
    wr_data    = wdata_q;
    wr_strb    = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
          wr_en      = 1'b1;
          wr_idx_raw = s_axi.S_AXI_AWADDR[ADDR_W-1:2];
          wr_data    = s_axi.S_AXI_WDATA;
          wr_strb    = s_axi.S_AXI_WSTRB;
          state_d    = S_B;
        end else if (s_axi.S_AXI_AWVALID) begin
          awidx_d = s_axi.S_AXI_AWADDR[ADDR_W-1:2];
          state_d = S_AW;
        end else if (s_axi.S_AXI_WVALID) begin
          wdata_d = s_axi.S_AXI_WDATA;
          wstrb_d = s_axi.S_AXI_WSTRB;
          state_d = S_W;
        end else if (s_axi.S_AXI_ARVALID) begin
          aridx_d = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
          state_d = S_RA;
        end
      end
      S_AW: begin
        if (s_axi.S_AXI_WVALID) begin
          wr_en   = 1'b1;
          wr_data = s_axi.S_AXI_WDATA;
          wr_strb = s_axi.S_AXI_WSTRB;
          state_d = S_B;
        end
      end
      S_W: begin
        if (s_axi.S_AXI_AWVALID) begin
          wr_en      = 1'b1;
          wr_idx_raw = s_axi.S_AXI_AWADDR[ADDR_W-1:2];
          state_d    = S_B;
        end
      end
      S_B:     if (s_axi.S_AXI_BREADY) state_d = S_IDLE;
      S_RA:    state_d = S_R;
      S_R:     if (s_axi.S_AXI_RREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_idx = 32'(wr_idx_raw);
  assign wr_ok  = idx_in_range(wr_idx);
  assign rd_idx = 32'(aridx_q);
  assign rd_ok  = idx_in_range(rd_idx);

  // Register file update: software CTRL writes beat hardware clears,
  // hardware sets of the sticky STATUS bits beat software W1C.
  always_comb begin
    ctrl_d   = ctrl_q;
    done_d   = done_q;
    seen_d   = seen_q;
    params_d = params_q;
    if (matw_done) ctrl_d[0] = 1'b0;
    if (fin)       ctrl_d[1] = 1'b0;
    if (wr_en && wr_ok) begin
      if (wr_idx == 32'd0 && wr_strb[0]) ctrl_d = wr_data[2:0];
      if (wr_idx == 32'd1 && wr_strb[0]) begin
        if (wr_data[1]) done_d = 1'b0;
        if (wr_data[2]) seen_d = 1'b0;
      end
      for (int i = 0; i < NUM_REGS - 2; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_idx == 32'(i + 2) && wr_strb[b])
            params_d[i*32 + b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
    if (fin)       done_d = 1'b1;
    if (matw_done) seen_d = 1'b1;
  end

  always_comb begin
    rd_data = 32'h0;
    if (rd_ok) begin
      if (rd_idx == 32'd0) rd_data = {29'h0, ctrl_q};
      if (rd_idx == 32'd1) rd_data = {29'h0, seen_q, done_q, ctrl_q[1]};
      for (int i = 0; i < NUM_REGS - 2; i++) begin
        if (rd_idx == 32'(i + 2)) rd_data = params_q[i*32 +: 32];
      end
    end
  end

  // Handshake outputs are registered from the next-state decode
  always_comb begin
    awready_d = (state_d == S_IDLE) || (state_d == S_W);
    wready_d  = (state_d == S_IDLE) || (state_d == S_AW);
    arready_d = (state_d == S_IDLE);
    bvalid_d  = (state_d == S_B);
    rvalid_d  = (state_d == S_R);
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (wr_en) bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
    if (state_q == S_RA) begin
      rdata_d = rd_data;
      rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      awidx_q   <= '0;
      aridx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      arready_q <= 1'b1;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
      params_q  <= {(NUM_REGS-2){PARAM_RST}};
    end else begin
      state_q   <= state_d;
      awidx_q   <= awidx_d;
      aridx_q   <= aridx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      seen_q    <= seen_d;
      params_q  <= params_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign matw   = ctrl_q[0];
  assign run    = ctrl_q[1];
  assign last   = ctrl_q[2];
  assign params = params_q;
endmodule

// File: tb/tb_hpu_axil_regs.sv
// Scoreboard bench for hpu_axil_regs: directed cases plus random traffic
// checked against a register-level reference model.
module tb_hpu_axil_regs;
  localparam int          ADDR_W    = 12;
  localparam int          NUM_REGS  = 8;
  localparam logic [31:0] PARAM_RST = 32'h0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic matw_done = 1'b0;
  logic fin = 1'b0;
  logic matw, run, last;
  logic [(NUM_REGS-2)*32-1:0] params;

  hpu_axil_regs_if #(.ADDR_W(ADDR_W)) bus ();

  hpu_axil_regs #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .PARAM_RST(PARAM_RST)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus.slave),
    .matw_done(matw_done), .fin(fin),
    .matw(matw), .run(run), .last(last), .params(params)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: architectural register contents only
  logic [31:0] m_param [NUM_REGS];
  bit m_matw, m_run, m_last, m_done, m_seen;
  logic [1:0] b_q [$];
  rexp_t      r_q [$];
  logic [1:0] mon_b;
  rexp_t      mon_r;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_param[i] = PARAM_RST;
    {m_matw, m_run, m_last, m_done, m_seen} = '0;
  endfunction

  function automatic logic [1:0] model_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input bit fin_p, input bit md_p);
    int idx = int'(addr[ADDR_W-1:2]);
    if (md_p)  m_matw = 1'b0;
    if (fin_p) m_run  = 1'b0;
    if (idx >= NUM_REGS) begin
      if (fin_p) m_done = 1'b1;
      if (md_p)  m_seen = 1'b1;
      return 2'b10;
    end
    if (idx == 0 && strb[0]) {m_last, m_run, m_matw} = data[2:0];
    if (idx == 1 && strb[0]) begin
      if (data[1]) m_done = 1'b0;
      if (data[2]) m_seen = 1'b0;
    end
    if (idx >= 2)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_param[idx][b*8 +: 8] = data[b*8 +: 8];
    if (fin_p) m_done = 1'b1;
    if (md_p)  m_seen = 1'b1;
    return 2'b00;
  endfunction

  function automatic rexp_t model_read(input logic [ADDR_W-1:0] addr);
    int idx = int'(addr[ADDR_W-1:2]);
    rexp_t e;
    e.resp = 2'b00;
    if (idx >= NUM_REGS) begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end else if (idx == 0) e.data = {29'h0, m_last, m_run, m_matw};
    else if (idx == 1)     e.data = {29'h0, m_seen, m_done, m_run};
    else                   e.data = m_param[idx];
    return e;
  endfunction

  function automatic void check_outputs();
    chk("matw_out", 32'(matw), 32'(m_matw));
    chk("run_out",  32'(run),  32'(m_run));
    chk("last_out", 32'(last), 32'(m_last));
    for (int i = 0; i < NUM_REGS - 2; i++)
      chk($sformatf("param%0d_out", i + 2), params[i*32 +: 32], m_param[i+2]);
  endfunction

  // Monitor: every completed response is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
      if (b_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL bresp_unexpected: got %h with no write outstanding", bus.S_AXI_BRESP);
      end else begin
        mon_b = b_q.pop_front();
        chk("bresp", 32'(bus.S_AXI_BRESP), 32'(mon_b));
      end
    end
    if (rst_n && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      if (r_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL rresp_unexpected: got %h with no read outstanding", bus.S_AXI_RDATA);
      end else begin
        mon_r = r_q.pop_front();
        chk("rdata", bus.S_AXI_RDATA, mon_r.data);
        chk("rresp", 32'(bus.S_AXI_RRESP), 32'(mon_r.resp));
      end
    end
  end

  task automatic pulse(input bit f, input bit md);
    fin = f;
    matw_done = md;
    @(posedge clk); #1;
    fin = 1'b0;
    matw_done = 1'b0;
    if (md) begin m_matw = 1'b0; m_seen = 1'b1; end
    if (f)  begin m_run  = 1'b0; m_done = 1'b1; end
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit fin_p, input bit md_p);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    int n = 0;
    b_q.push_back(model_write(addr, data, strb, fin_p, md_p));
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 20) begin
      bus.S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      bus.S_AXI_WVALID  = !w_done && cyc >= w_dly;
      fin       = fin_p && (aw_done || bus.S_AXI_AWVALID) && (w_done || bus.S_AXI_WVALID);
      matw_done = md_p  && (aw_done || bus.S_AXI_AWVALID) && (w_done || bus.S_AXI_WVALID);
      @(negedge clk);
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY)   w_done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    fin = 1'b0;
    matw_done = 1'b0;
    chk("write_addr_data_accepted", 32'({aw_done, w_done}), 32'd3);
    @(negedge clk);
    while (!bus.S_AXI_BVALID && n < 10) begin @(negedge clk); n++; end
    chk("bvalid_present", 32'(bus.S_AXI_BVALID), 32'd1);
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bvalid_hold", 32'(bus.S_AXI_BVALID), 32'd1);
      chk("arready_in_b", 32'(bus.S_AXI_ARREADY), 32'd0);
    end
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    chk("bvalid_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    @(posedge clk); #1;
    check_outputs();
  endtask

  // Starts one cycle after the AR handshake edge
  task automatic finish_read(input int r_dly);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_RVALID && n < 10);
    chk("read_latency", 32'(n), 32'd2);
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rvalid_hold", 32'(bus.S_AXI_RVALID), 32'd1);
    end
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    chk("rvalid_drop", 32'(bus.S_AXI_RVALID), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, input int r_dly);
    int n = 0;
    r_q.push_back(model_read(addr));
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    while (!bus.S_AXI_ARREADY && n < 10) begin @(negedge clk); n++; end
    chk("arready_seen", 32'(bus.S_AXI_ARREADY), 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    finish_read(r_dly);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int idx;
    int sel;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("rst_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    chk("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    chk("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    chk("rst_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
    chk("rst_rresp",   32'(bus.S_AXI_RRESP),   32'd0);
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    axi_read(12'h000, 0);
    axi_read(12'h004, 1);
    axi_read(12'h008, 0);

    axi_write(12'h008, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0, 0);
    axi_write(12'h00C, 32'h11223344, 4'b0101, 0, 3, 0, 0, 0);
    chk("param2_deadbeef", params[31:0],  32'hDEADBEEF);
    chk("param3_strobed",  params[63:32], 32'h00220044);
    axi_write(12'h010, 32'hCAFEF00D, 4'b1010, 3, 0, 1, 0, 0);

    axi_write(12'h000, 32'h3, 4'b0001, 0, 0, 0, 0, 0);
    chk("matw_set", 32'(matw), 32'd1);
    chk("run_set",  32'(run),  32'd1);
    pulse(0, 1);
    chk("matw_hw_clear", 32'(matw), 32'd0);
    pulse(1, 0);
    chk("run_hw_clear", 32'(run), 32'd0);
    axi_read(12'h004, 0);
    axi_write(12'h004, 32'h2, 4'b0001, 0, 0, 0, 0, 0);
    axi_read(12'h004, 0);

    pulse(1, 0);
    axi_write(12'h004, 32'h2, 4'b0001, 0, 0, 0, 1, 0);
    axi_read(12'h004, 0);
    axi_write(12'h000, 32'h2, 4'b0001, 1, 0, 0, 1, 0);
    chk("run_sw_beats_fin", 32'(run), 32'd1);
    axi_write(12'h000, 32'h5, 4'b0000, 0, 0, 0, 0, 0);
    axi_write(12'h008, 32'h12345678, 4'b0000, 0, 0, 0, 0, 0);

    axi_write(ADDR_W'(NUM_REGS * 4), 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0, 0);
    axi_read(ADDR_W'(NUM_REGS * 4), 0);
    axi_read(12'hFFC, 2);

    // Write and read presented together: write first, read sees new value
    b_q.push_back(model_write(12'h014, 32'hA5A55A5A, 4'b1111, 0, 0));
    r_q.push_back(model_read(12'h014));
    bus.S_AXI_AWADDR = 12'h014; bus.S_AXI_WDATA = 32'hA5A55A5A; bus.S_AXI_WSTRB = 4'b1111;
    bus.S_AXI_ARADDR = 12'h014;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    chk("simul_aw_accept", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'd3);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("simul_bvalid_hold", 32'(bus.S_AXI_BVALID), 32'd1);
      chk("simul_arready_low", 32'(bus.S_AXI_ARREADY), 32'd0);
      @(posedge clk); #1;
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    chk("simul_arready_low_b", 32'(bus.S_AXI_ARREADY), 32'd0);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    chk("simul_arready_idle", 32'(bus.S_AXI_ARREADY), 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    finish_read(0);

    // Reset with a write address pending: response is dropped
    bus.S_AXI_AWADDR = 12'h008; bus.S_AXI_AWVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("midrst_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    chk("midrst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(12'h008, 0);

    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 9));
      idx = (sel <= NUM_REGS) ? sel : int'($urandom_range(NUM_REGS, (1 << (ADDR_W - 2)) - 1));
      a = ADDR_W'(idx * 4 + int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        axi_read(a, int'($urandom_range(0, 3)));
      end else begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 4) == 0) pulse($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    chk("b_queue_drained", 32'(b_q.size()), 32'd0);
    chk("r_queue_drained", 32'(r_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hpu_axil_regs.md
Name: hpu_axil_regs

Overview:
- Parametrised AXI-Lite slave register block for the HPU top level; generalises the current inline control-register logic.
- Adds per-byte write strobes, decode-error responses, a W1C status register, hardware auto-clear of matw/run, and NUM_REGS-2 generic parameter registers exported to the datapath (addr_i, addr_j, random_num, ...).
- Sits between the PS AXI-Lite master and the stream/exec controllers.

Parameters:
ADDR_W, 12, AXI-Lite address width; bits [1:0] ignored.
NUM_REGS, 8, number of 32-bit registers decoded at byte offsets 0x00..(NUM_REGS-1)*4; min 3, max 2^(ADDR_W-2).
PARAM_RST, 0, reset value of every parameter register.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  async active-low reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
matw_done  in  1  one-cycle pulse: matrix write finished
fin  in  1  one-cycle pulse: run finished (s_fin)
matw  out  1  CTRL[0]
run  out  1  CTRL[1]
last  out  1  CTRL[2]
params  out  (NUM_REGS-2)*32  registers 2..NUM_REGS-1, reg 2 in bits [31:0]

Behaviour:
- Reset (async assert, sync deassert by system): FSM IDLE; all *READY/*VALID low except as given by IDLE state decode; CTRL=0, STATUS=0, params=PARAM_RST, RDATA=0, BRESP/RRESP=00.
- FSM states: IDLE, AW (addr held, waiting data), W (data held, waiting addr), B (BVALID=1), RA (read decode), R (RVALID=1).
- AWREADY = IDLE|W; WREADY = IDLE|AW; ARREADY = IDLE.
- IDLE: AWVALID&WVALID -> capture both, B. AWVALID only -> AW. WVALID only -> W. ARVALID only (no AW/W valid) -> RA. Writes have priority over reads when both are presented.
- AW+WVALID -> B; W+AWVALID -> B. Register update happens in the cycle of entry to B (one write per transaction).
- B: hold BVALID/BRESP until BREADY -> IDLE. RA: load RDATA/RRESP -> R (1 cycle). R: hold until RREADY -> IDLE. Read latency: RVALID 2 cycles after ARVALID&ARREADY.
- Decode: index = addr[ADDR_W-1:2]; index >= NUM_REGS -> SLVERR, no state change, RDATA=0.
- 0x00 CTRL RW, bits[2:0] {last,run,matw}, bits[31:3] read 0; byte 0 written only if WSTRB[0].
- 0x04 STATUS: bit0 busy (=run, RO); bit1 done (sticky, set by fin; W1C when WSTRB[0]); bit2 matw_seen (sticky, set by matw_done; W1C); other bits 0.
- 0x08.. params RW; each byte updated only when its WSTRB bit set.
- Hardware clears: matw_done clears matw; fin clears run and sets done. Same-cycle software write to CTRL wins over hardware clear; same-cycle fin and W1C of done: set wins (done=1).
- WSTRB=0000: OKAY response, no register change.
- Reset mid-transaction: FSM returns to IDLE immediately, response dropped.

Test Plan:
- Reset then read 0x00, 0x04, 0x08 -> RDATA 0, 0, PARAM_RST, RRESP 00, RVALID 2 cycles after AR handshake.
- AW and W same cycle to 0x08 data 0xDEADBEEF WSTRB 1111; AW 3 cycles before W to 0x0C WSTRB 0101 data 0x11223344 -> params[31:0]=DEADBEEF, params[63:32]=0x00220044 (from 0), BRESP 00.
- Write 0x00 = 0x3 -> matw=run=1; pulse matw_done -> matw=0; pulse fin -> run=0, STATUS=0x6; write 0x04=0x2 -> STATUS=0x4.
- fin pulse in the same cycle as W1C of done -> STATUS bit1 stays 1; CTRL write 0x2 in same cycle as fin -> run=1.
- Write/read address NUM_REGS*4 -> BRESP/RRESP=10, RDATA=0, no register changes.
- AWVALID and ARVALID asserted together in IDLE -> write completes first, then read returns post-write value; BREADY held low 5 cycles -> BVALID held, ARREADY low throughout.
